// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and elaboration-time helpers for the
// iterative CORDIC cosine core.
package cordic_pkg;

   localparam int DATA_W = 32;
   localparam int FRAC_W = 31;

   // 1/prod(sqrt(1+2^-2i)) = 0.607252935 in Q1.31
   localparam logic [DATA_W-1:0] K_Q31 = 32'h4DBA76D4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic logic [63:0] k_scaled(input int guard_bits);
      return {32'd0, K_Q31} << guard_bits;
   endfunction

   function automatic bit max_iter_check(input int iterations);
      return (iterations >= 8) && (iterations <= 31);
   endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational arctangent ROM: atan(2^-idx) in Q1.(31+GUARD_BITS), with
// entries computed from real arithmetic at elaboration and rounded to nearest.
module cordic_atan_lut
   import cordic_pkg::*;
#(
   parameter int GUARD_BITS = 2
) (
   input  logic [4:0]                   idx,
   output logic [DATA_W+GUARD_BITS-1:0] atan
);

   localparam int AW = DATA_W + GUARD_BITS;

   // atan(1) is taken directly; for x <= 0.5 the Taylor series converges fast.
   function automatic logic [63:0] atan_fixed(input int i, input int frac);
      real scale;
      real x;
      real x2;
      real term;
      real sum;
      real sgn;
      scale = 1.0;
      for (int k = 0; k < frac; k++) scale = scale * 2.0;
      if (i == 0) begin
         sum = 0.785398163397448309616;
      end else begin
         x = 1.0;
         for (int k = 0; k < i; k++) x = x / 2.0;
         x2   = x * x;
         term = x;
         sum  = 0.0;
         sgn  = 1.0;
         for (int n = 0; n < 32; n++) begin
            sum  = sum + sgn * term / real'(2 * n + 1);
            term = term * x2;
            sgn  = -sgn;
         end
      end
      return 64'(longint'(sum * scale));
   endfunction

   logic [AW-1:0] rom [32];

   for (genvar g = 0; g < 32; g++) begin : g_rom
      localparam logic [63:0] ENTRY = atan_fixed(g, FRAC_W + GUARD_BITS);
      assign rom[g] = ENTRY[AW-1:0];
   end

   assign atan = rom[idx];

endmodule

// File: rtl/cordic_cos_iter.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, unsigned Q1.31
// angle in radians to unsigned Q1.31 cosine, valid/ready on both sides.
module cordic_cos_iter
   import cordic_pkg::*;
#(
   parameter int ITERATIONS = 16,
   parameter int GUARD_BITS = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_angle,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_cos
);

   localparam int W  = DATA_W + GUARD_BITS + 2;
   localparam int AW = DATA_W + GUARD_BITS;

   localparam logic signed [W-1:0] K_INIT    = W'(k_scaled(GUARD_BITS));
   localparam logic signed [W:0]   RND       = (W + 1)'((64'd1 << GUARD_BITS) >> 1);
   localparam logic [4:0]          ITER_LAST = 5'(ITERATIONS - 1);

   if (!max_iter_check(ITERATIONS)) begin : g_bad_iterations
      $error("cordic_cos_iter: ITERATIONS must be within 8..31");
   end

   state_t state, state_nxt;
   logic [4:0] iter;
   logic signed [W-1:0] x, y, z;
   logic signed [W-1:0] x_nxt, y_nxt, z_nxt;
   logic signed [W-1:0] x_sh, y_sh, atan_ext, z_init;
   logic [AW-1:0] atan;
   logic signed [W:0] rnd_sum, rounded;
   logic [DATA_W-1:0] cos_sat;
   logic last;

   cordic_atan_lut #(
      .GUARD_BITS(GUARD_BITS)
   ) u_atan_lut (
      .idx  (iter),
      .atan (atan)
   );

   assign atan_ext = signed'({2'b00, atan});
   assign z_init   = signed'(W'(in_angle) << GUARD_BITS);
   assign last     = (iter == ITER_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case leaves it unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Direction comes from the sign of the residual angle.
   always_comb begin
      x_sh = x >>> iter;
      y_sh = y >>> iter;
      if (!z[W-1]) begin
         x_nxt = x - y_sh;
         y_nxt = y + x_sh;
         z_nxt = z - atan_ext;
      end else begin
         x_nxt = x + y_sh;
         y_nxt = y - x_sh;
         z_nxt = z + atan_ext;
      end
   end

   // Round half up into Q1.31, then clamp to the unsigned output range.
   always_comb begin
      rnd_sum = {x_nxt[W-1], x_nxt} + RND;
      rounded = rnd_sum >>> GUARD_BITS;
      if (rounded[W])
         cos_sat = '0;
      else if (rounded[W-1:DATA_W] != '0)
         cos_sat = '1;
      else
         cos_sat = rounded[DATA_W-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x       <= '0;
         y       <= '0;
         z       <= '0;
         iter    <= '0;
         out_cos <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  x    <= K_INIT;
                  y    <= '0;
                  z    <= z_init;
                  iter <= '0;
               end
            end
            RUN: begin
               x <= x_nxt;
               y <= y_nxt;
               z <= z_nxt;
               if (last) out_cos <= cos_sat;
               else      iter    <= iter + 5'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_cos_iter.sv
// Scoreboard bench for cordic_cos_iter: stimulus pushes expected operations,
// a monitor checks latency and cos value against a real-arithmetic model.
module tb_cordic_cos_iter;

   localparam int  ITER = 16;
   localparam longint TOL = longint'(1) << (32 - ITER);

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_angle;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_cos;

   cordic_cos_iter #(
      .ITERATIONS (ITER),
      .GUARD_BITS (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_angle  (in_angle),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_cos   (out_cos)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] angle;
      longint      acc_cyc;
      bit          chk;
   } exp_t;

   exp_t   sb[$];
   int     errors = 0;
   int     checks = 0;
   longint cyc = 0;
   bit     prev_v = 1'b0;
   int     idle_valids;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input bit ok, input longint act, input longint req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   function automatic longint ref_cos(input logic [31:0] a);
      real    r;
      longint e;
      r = real'(a) / 2147483648.0;
      e = longint'($cos(r) * 2147483648.0);
      if (e < 0) e = 0;
      return e;
   endfunction

   // Monitor: latency on the rising out_valid, value on each handshake.
   always @(negedge clk) begin
      exp_t   e;
      longint diff;
      if (reset) begin
         prev_v = 1'b0;
      end else begin
         if (out_valid && !prev_v) begin
            if (sb.size() == 0)
               check("unexpected_out_valid", 1'b0, 1, 0);
            else
               check("latency", (cyc - sb[0].acc_cyc + 1) == ITER + 1,
                     cyc - sb[0].acc_cyc + 1, ITER + 1);
         end
         if (out_valid && out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
               diff = longint'(out_cos) - ref_cos(e.angle);
               check($sformatf("cos(0x%08h)", e.angle), diff <= TOL && diff >= -TOL,
                     longint'(out_cos), ref_cos(e.angle));
            end
         end
         prev_v = out_valid;
      end
   end

   task automatic send(input logic [31:0] a, input bit chk);
      bit done = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_angle = a;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back('{a, cyc + 1, chk});
            done = 1'b1;
         end
      end
      if (!done) check("accept_timeout", 1'b0, 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         if (sb.size() == 0 && in_ready) done = 1'b1;
      end
      if (!done) check("completion_timeout", 1'b0, sb.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] hold;
      bit          seen;

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_angle  = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_in_ready", in_ready == 1'b1, in_ready, 1);
      check("reset_out_valid", out_valid == 1'b0, out_valid, 0);
      check("reset_out_cos", out_cos == 32'd0, out_cos, 0);
      reset = 1'b0;

      // Directed angles: zero, 1.0 rad, 0.5 rad.
      send(32'h0000_0000, 1'b1);
      wait_done();
      send(32'h8000_0000, 1'b1);
      wait_done();
      send(32'h4000_0000, 1'b1);
      wait_done();

      // Backpressure: result must hold while out_ready is low.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(32'h2468_ACE0, 1'b1);
      seen = 1'b0;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         seen = out_valid;
      end
      check("bp_out_valid_seen", seen, seen, 1);
      hold = out_cos;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         check("bp_hold", out_valid && out_cos == hold && !in_ready,
               {in_ready, out_valid, out_cos}, {1'b0, 1'b1, hold});
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_release_out_valid", out_valid == 1'b0, out_valid, 0);
      check("bp_release_in_ready", in_ready == 1'b1, in_ready, 1);

      // Busy drop: a second angle offered during RUN is ignored.
      send(32'h3000_0000, 1'b1);
      in_valid = 1'b1;
      in_angle = 32'h1234_5678;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         check("busy_in_ready_low", in_ready == 1'b0, in_ready, 0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_done();
      idle_valids = 0;
      for (int n = 0; n < 25; n++) begin
         @(negedge clk);
         if (out_valid) idle_valids++;
      end
      check("busy_no_extra_result", idle_valids == 0, idle_valids, 0);

      // Asynchronous reset at iteration 7 discards the operation.
      send(32'h5555_5555, 1'b1);
      repeat (7) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("midrun_reset_in_ready", in_ready == 1'b1, in_ready, 1);
      check("midrun_reset_out_valid", out_valid == 1'b0, out_valid, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      send(32'h6000_0000, 1'b1);
      wait_done();

      // Randomized in-contract angles.
      for (int n = 0; n < 40; n++) begin
         send(32'($urandom_range(0, 32'h8000_0000)), 1'b1);
         wait_done();
      end

      // Out-of-contract angles must still complete with correct latency.
      for (int n = 0; n < 6; n++) begin
         send(32'h8000_0001 + 32'($urandom_range(0, 32'h7FFF_FFFE)), 1'b0);
         wait_done();
      end
      send(32'hFFFF_FFFF, 1'b0);
      wait_done();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
